// File: rtl/regfile_wb_queue.sv
// -----------------------------------------------------------------------------
// regfile_wb_queue
//
// Writeback queue in front of the 32 x XLEN register file write port.
// Result producers push {addr, data} through a valid/ready handshake. Entries
// are held in an in-order circular buffer and retired at most one per cycle
// whenever the write port is available (wb_en). Writes to x0 are accepted but
// never stored.
//
// Decode can look up two operand addresses against the queued entries. A hit
// means the register file still holds a stale value for that register. With
// forwarding built in, the data of the youngest matching entry is also
// returned.
//
// Optional feature macro: REGFILE_WB_FWD_EN
//   defined   : the forwarding mux is built; fwd_data_* carry the youngest match
//   undefined : fwd_data_* are tied to 0; hit_* are still produced
//
// Parameters
//   DEPTH  number of FIFO entries (power of two, >= 2)
//   XLEN   data width
//
// Ports
//   clk                    clock, rising edge
//   rst                    asynchronous reset, active low
//   in_valid/in_ready      writeback request handshake
//   in_addr, in_data       destination register and result value
//   wb_en                  register-file write port available this cycle
//   reg_write, wr_addr,
//   data                   register-file write port (head entry)
//   rd_addr_1, rd_addr_2   operand addresses read by decode this cycle
//   hit_1, hit_2           a queued entry targets that operand address
//   fwd_data_1, fwd_data_2 data of the youngest matching queued entry
//   count                  number of occupied entries
// -----------------------------------------------------------------------------
module regfile_wb_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_addr,
    input  logic [XLEN-1:0]          in_data,
    input  logic                     wb_en,
    output logic                     reg_write,
    output logic [4:0]               wr_addr,
    output logic [XLEN-1:0]          data,
    input  logic [4:0]               rd_addr_1,
    input  logic [4:0]               rd_addr_2,
    output logic                     hit_1,
    output logic                     hit_2,
    output logic [XLEN-1:0]          fwd_data_1,
    output logic [XLEN-1:0]          fwd_data_2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]   head_reg;
    logic [AW-1:0]   tail_reg;
    logic [CW-1:0]   count_reg;

    logic [4:0]      addr_mem [DEPTH];
    logic [XLEN-1:0] data_mem [DEPTH];

    logic            not_empty;
    logic            full;
    logic            enq;
    logic            deq;

    assign not_empty = (count_reg != '0);
    assign full      = (count_reg == CW'(DEPTH));

    // A full queue can still accept when the head retires at the same edge.
    assign reg_write = not_empty && wb_en;
    assign in_ready  = !full || reg_write;
    assign deq       = reg_write;

    // x0 requests complete the handshake but are never stored.
    assign enq = in_valid && in_ready && (in_addr != 5'd0);

    assign wr_addr = not_empty ? addr_mem[head_reg] : 5'd0;
    assign data    = not_empty ? data_mem[head_reg] : '0;
    assign count   = count_reg;

    // -------------------------------------------------------------------------
    // Storage: one register per entry, written when the tail points at it.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    addr_mem[gi] <= 5'd0;
                    data_mem[gi] <= '0;
                end else if (enq && (tail_reg == AW'(gi))) begin
                    addr_mem[gi] <= in_addr;
                    data_mem[gi] <= in_data;
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Pointers and occupancy. Pointers are exactly AW bits wide so they wrap
    // modulo DEPTH on their own.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (enq) begin
                tail_reg <= tail_reg + AW'(1);
            end
            if (deq) begin
                head_reg <= head_reg + AW'(1);
            end
            case ({enq, deq})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Pending-write lookup, one instance per read port.
    // Entries are scanned from oldest (head) to youngest, so a later match
    // overrides an earlier one and the youngest entry supplies the data.
    // The head is included: the register file only commits it at the coming
    // edge, so a read in this cycle still sees the old value.
    // -------------------------------------------------------------------------
    logic [4:0] rd_addr_p [2];
    assign rd_addr_p[0] = rd_addr_1;
    assign rd_addr_p[1] = rd_addr_2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic            port_hit;
            logic [XLEN-1:0] port_fwd;

            always_comb begin
                logic [AW-1:0] idx;
                port_hit = 1'b0;
                port_fwd = '0;
                idx      = head_reg;
                for (int j = 0; j < DEPTH; j++) begin
                    idx = head_reg + AW'(j);
                    if ((CW'(j) < count_reg) &&
                        (rd_addr_p[gi] != 5'd0) &&
                        (addr_mem[idx] == rd_addr_p[gi])) begin
                        port_hit = 1'b1;
`ifdef REGFILE_WB_FWD_EN
                        port_fwd = data_mem[idx];
`endif
                    end
                end
            end
        end
    endgenerate

    assign hit_1      = g_port[0].port_hit;
    assign hit_2      = g_port[1].port_hit;
    assign fwd_data_1 = g_port[0].port_fwd;
    assign fwd_data_2 = g_port[1].port_fwd;

endmodule

// File: tb/tb_regfile_wb_queue.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_queue
//
// Self-checking bench for regfile_wb_queue (DEPTH=4, XLEN=64).
// A scoreboard queue holds the entries expected to be pending. Every cycle,
// at the falling edge, the DUT outputs are compared against values derived
// from the scoreboard. Then the scoreboard pops the retired head and pushes
// the newly accepted entry. A reference register file updated at accept time
// is compared with a shadow register file written from the DUT write port.
// -----------------------------------------------------------------------------
module tb_regfile_wb_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 64;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_addr;
    logic [XLEN-1:0]  in_data;
    logic             wb_en;
    logic             reg_write;
    logic [4:0]       wr_addr;
    logic [XLEN-1:0]  data;
    logic [4:0]       rd_addr_1;
    logic [4:0]       rd_addr_2;
    logic             hit_1;
    logic             hit_2;
    logic [XLEN-1:0]  fwd_data_1;
    logic [XLEN-1:0]  fwd_data_2;
    logic [2:0]       count;

    regfile_wb_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .wb_en      (wb_en),
        .reg_write  (reg_write),
        .wr_addr    (wr_addr),
        .data       (data),
        .rd_addr_1  (rd_addr_1),
        .rd_addr_2  (rd_addr_2),
        .hit_1      (hit_1),
        .hit_2      (hit_2),
        .fwd_data_1 (fwd_data_1),
        .fwd_data_2 (fwd_data_2),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]      a;
        logic [XLEN-1:0] d;
    } ent_t;

    ent_t            sb[$];
    logic [4:0]      ret_log[$];
    logic [XLEN-1:0] ref_rf    [32];
    logic [XLEN-1:0] shadow_rf [32];

    int   n_checks;
    int   n_fail;
    logic last_accept;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected lookup for one port: youngest matching scoreboard entry.
    task automatic exp_lookup(input logic [4:0] ra, output logic h, output logic [XLEN-1:0] f);
        h = 1'b0;
        f = '0;
        for (int i = 0; i < sb.size(); i++) begin
            if (ra != 5'd0 && sb[i].a == ra) begin
                h = 1'b1;
                f = sb[i].d;
            end
        end
`ifndef REGFILE_WB_FWD_EN
        f = '0;
`endif
    endtask

    // One clock cycle. Called at posedge+1; drives inputs, checks at negedge,
    // updates models, returns at the next posedge+1.
    task automatic step(input logic v, input logic [4:0] a, input logic [XLEN-1:0] d,
                        input logic w, input logic [4:0] r1, input logic [4:0] r2);
        logic            e_rw;
        logic            e_rdy;
        logic [4:0]      e_wa;
        logic [XLEN-1:0] e_wd;
        logic            e_h1;
        logic            e_h2;
        logic [XLEN-1:0] e_f1;
        logic [XLEN-1:0] e_f2;
        in_valid  = v;
        in_addr   = a;
        in_data   = d;
        wb_en     = w;
        rd_addr_1 = r1;
        rd_addr_2 = r2;
        @(negedge clk);
        e_rw  = (sb.size() != 0) && w;
        e_rdy = (sb.size() != DEPTH) || e_rw;
        e_wa  = (sb.size() != 0) ? sb[0].a : 5'd0;
        e_wd  = (sb.size() != 0) ? sb[0].d : '0;
        exp_lookup(r1, e_h1, e_f1);
        exp_lookup(r2, e_h2, e_f2);
        check_val("count",      64'(count),      64'(sb.size()));
        check_val("in_ready",   64'(in_ready),   64'(e_rdy));
        check_val("reg_write",  64'(reg_write),  64'(e_rw));
        check_val("wr_addr",    64'(wr_addr),    64'(e_wa));
        check_val("data",       data,            e_wd);
        check_val("hit_1",      64'(hit_1),      64'(e_h1));
        check_val("hit_2",      64'(hit_2),      64'(e_h2));
        check_val("fwd_data_1", fwd_data_1,      e_f1);
        check_val("fwd_data_2", fwd_data_2,      e_f2);
        if (reg_write === 1'b1) begin
            ret_log.push_back(wr_addr);
            if (wr_addr != 5'd0) shadow_rf[wr_addr] = data;
        end
        if (e_rw) void'(sb.pop_front());
        last_accept = v && e_rdy;
        if (last_accept && a != 5'd0) begin
            sb.push_back('{a: a, d: d});
            ref_rf[a] = d;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 64 && sb.size() != 0; k++) begin
            step(1'b0, 5'd0, '0, 1'b1, 5'd0, 5'd0);
        end
        check_val("drain_done", 64'(sb.size()), 64'd0);
    endtask

    logic [XLEN-1:0] exp_fwd;
    int              n_acc;
    logic [4:0]      exp_order [5];

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        last_accept = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ref_rf[i]    = '0;
            shadow_rf[i] = '0;
        end
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_addr   = 5'd0;
        in_data   = '0;
        wb_en     = 1'b1;
        rd_addr_1 = 5'd0;
        rd_addr_2 = 5'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_reg_write", 64'(reg_write), 64'd0);
        check_val("rst_wr_addr",   64'(wr_addr),   64'd0);
        check_val("rst_data",      data,           64'd0);
        check_val("rst_count",     64'(count),     64'd0);
        check_val("rst_in_ready",  64'(in_ready),  64'd1);
        check_val("rst_hit_1",     64'(hit_1),     64'd0);
        check_val("rst_fwd_1",     fwd_data_1,     64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single write: one-cycle load-to-commit
        step(1'b1, 5'd5, 64'hDEADBEEF, 1'b1, 5'd5, 5'd0);
        in_valid = 1'b0;
        #1;
        check_val("single_rw",    64'(reg_write), 64'd1);
        check_val("single_addr",  64'(wr_addr),   64'd5);
        check_val("single_data",  data,           64'hDEADBEEF);
        check_val("single_hit",   64'(hit_1),     64'd1);
        step(1'b0, 5'd0, '0, 1'b1, 5'd5, 5'd0);
        step(1'b0, 5'd0, '0, 1'b1, 5'd0, 5'd0);
        check_val("single_empty", 64'(count),     64'd0);

        // x0 drop
        step(1'b1, 5'd0, 64'h1234, 1'b1, 5'd0, 5'd0);
        in_valid = 1'b0;
        #1;
        check_val("x0_count", 64'(count),     64'd0);
        check_val("x0_rw",    64'(reg_write), 64'd0);
        step(1'b0, 5'd0, '0, 1'b1, 5'd0, 5'd0);

        // Fill and backpressure
        ret_log.delete();
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 5'(i), 64'(100 + i), 1'b0, 5'd0, 5'd0);
        end
        in_valid = 1'b0;
        #1;
        check_val("full_count", 64'(count),    64'd4);
        check_val("full_ready", 64'(in_ready), 64'd0);
        step(1'b1, 5'd6, 64'd106, 1'b1, 5'd3, 5'd6);
        step(1'b0, 5'd0, '0, 1'b1, 5'd0, 5'd0);
        drain();
        exp_order = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd6};
        check_val("order_len", 64'(ret_log.size()), 64'd5);
        for (int i = 0; i < 5 && i < ret_log.size(); i++) begin
            check_val($sformatf("order_%0d", i), 64'(ret_log[i]), 64'(exp_order[i]));
        end

        // Forwarding priority
        step(1'b1, 5'd7, 64'hA, 1'b0, 5'd0, 5'd0);
        step(1'b1, 5'd7, 64'hB, 1'b0, 5'd0, 5'd0);
        step(1'b0, 5'd0, '0, 1'b0, 5'd7, 5'd0);
`ifdef REGFILE_WB_FWD_EN
        exp_fwd = 64'hB;
`else
        exp_fwd = 64'h0;
`endif
        check_val("fwd_hit_1", 64'(hit_1),  64'd1);
        check_val("fwd_data",  fwd_data_1, exp_fwd);
        check_val("fwd_hit_2", 64'(hit_2),  64'd0);
        drain();

        // Reset mid-drain
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 5'(10 + i), 64'(200 + i), 1'b0, 5'd0, 5'd0);
        end
        in_valid  = 1'b0;
        wb_en     = 1'b1;
        rd_addr_1 = 5'd11;
        #2;
        rst = 1'b0;
        #1;
        check_val("mrst_rw",    64'(reg_write), 64'd0);
        check_val("mrst_addr",  64'(wr_addr),   64'd0);
        check_val("mrst_data",  data,           64'd0);
        check_val("mrst_hit_1", 64'(hit_1),     64'd0);
        check_val("mrst_fwd_1", fwd_data_1,     64'd0);
        check_val("mrst_count", 64'(count),     64'd0);
        check_val("mrst_ready", 64'(in_ready),  64'd1);
        sb.delete();
        for (int i = 0; i < 32; i++) ref_rf[i] = shadow_rf[i];
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 5'd0, '0, 1'b1, 5'd11, 5'd12);
        end

        // Random soak
        n_acc = 0;
        for (int cyc = 0; cyc < 20000 && n_acc < 1000; cyc++) begin
            logic [4:0] ra;
            ra = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            step(($urandom_range(0, 3) != 0), ra, {$urandom, $urandom},
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            if (last_accept) n_acc++;
        end
        check_val("soak_accepts", 64'(n_acc), 64'd1000);
        drain();
        for (int i = 0; i < 32; i++) begin
            check_val($sformatf("rf_x%0d", i), shadow_rf[i], (i == 0) ? 64'd0 : ref_rf[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
